pixel_vram_arbiter: RTL

PIXEL_VRAM_ARBITER -- requirements
Module: pixel_vram_arbiter

---
 rtl/pixel_vram_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/pixel_vram_arbiter.sv
// -----------------------------------------------------------------------------
// pixel_vram_arbiter
//
// Shares one single-port pixel VRAM between a display scan-out engine and a
// CPU. The display has priority. A CPU access is latched and waits until it
// finds a cycle where the display is not reading, then takes that cycle.
//
// Optional feature macro: PIXEL_VRAM_ARBITER_STARVE_EN
//   When defined, a CPU access that has been blocked by the display for
//   STARVE_MAX consecutive cycles takes one display slot. The display sees its
//   previous pixel repeated for that slot.
//   When undefined, the display has strict priority and the CPU can wait
//   forever.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   disp_req, disp_addr   display read request / address (every cycle)
//   disp_q                display pixel data
//   cpu_start             one-cycle request pulse; samples cpu_we/addr/data
//   cpu_we, cpu_addr      CPU access type / address
//   cpu_data              CPU write data
//   cpu_q                 CPU read data (held until the next read completes)
//   cpu_done              one-cycle completion pulse
//   cpu_busy              CPU access pending or in flight
//   vram_addr, vram_d     VRAM address / write data
//   vram_we               VRAM write enable
//   vram_q                VRAM read data, one cycle after the address
// -----------------------------------------------------------------------------
module pixel_vram_arbiter #(
   parameter int ADDR_W     = 17,
   parameter int DATA_W     = 24,
   parameter int STARVE_MAX = 64
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic [DATA_W-1:0] disp_q,
   input  logic              cpu_start,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_data,
   output logic [DATA_W-1:0] cpu_q,
   output logic              cpu_done,
   output logic              cpu_busy,
   output logic [ADDR_W-1:0] vram_addr,
   output logic [DATA_W-1:0] vram_d,
   output logic              vram_we,
   input  logic [DATA_W-1:0] vram_q
);

   typedef enum logic [1:0] {IDLE, PEND, ISSUE, RWAIT} state_t;

   state_t            state, state_nxt;
   logic              accept;
   logic              steal;
   logic              we_lat;
   logic [ADDR_W-1:0] addr_lat;
   logic [DATA_W-1:0] data_lat;
   logic [DATA_W-1:0] cpu_q_reg;
   logic [DATA_W-1:0] disp_hold;
   logic              disp_rd_d;

   // ---------------------------------------------------------------------------
   // Starvation stealing
   // ---------------------------------------------------------------------------
`ifdef PIXEL_VRAM_ARBITER_STARVE_EN
   // Counts PEND cycles lost to the display. The count is checked before it
   // is incremented, so with STARVE_MAX=N the CPU loses N slots and is granted
   // in the (N+1)th PEND cycle, taking the following cycle as ISSUE.
   logic [7:0] starve_cnt;

   assign steal = disp_req && (int'(starve_cnt) >= STARVE_MAX);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         starve_cnt <= '0;
      else if (state != PEND || state_nxt != PEND)
         starve_cnt <= '0;
      else if (disp_req && starve_cnt != 8'hFF)
         starve_cnt <= starve_cnt + 8'd1;
   end
`else
   logic unused_starve_max;

   assign steal             = 1'b0;
   assign unused_starve_max = (STARVE_MAX != 0);
`endif

   // ---------------------------------------------------------------------------
   // Access FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // The display owns the VRAM port in every cycle except ISSUE. cpu_done and
   // cpu_busy are decoded from the state, so a reset clears them immediately.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      cpu_done  = 1'b0;
      cpu_busy  = 1'b0;
      vram_addr = disp_addr;
      vram_we   = 1'b0;
      case (state)
         IDLE: begin
            if (cpu_start) begin
               accept    = 1'b1;
               state_nxt = PEND;
            end
         end
         PEND: begin
            cpu_busy = 1'b1;
            if (!disp_req || steal) state_nxt = ISSUE;
         end
         ISSUE: begin
            vram_addr = addr_lat;
            vram_we   = we_lat;
            if (we_lat) begin
               cpu_done  = 1'b1;
               state_nxt = IDLE;
            end else begin
               cpu_busy  = 1'b1;
               state_nxt = RWAIT;
            end
         end
         RWAIT: begin
            cpu_done  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // CPU request latch and read data
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         we_lat   <= 1'b0;
         addr_lat <= '0;
         data_lat <= '0;
      end else if (accept) begin
         we_lat   <= cpu_we;
         addr_lat <= cpu_addr;
         data_lat <= cpu_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)            cpu_q_reg <= '0;
      else if (state == RWAIT) cpu_q_reg <= vram_q;
   end

   // Read data is forwarded straight from the VRAM in the done cycle so it is
   // valid together with cpu_done, then held in cpu_q_reg.
   assign cpu_q  = (state == RWAIT) ? vram_q : cpu_q_reg;
   assign vram_d = data_lat;

   // ---------------------------------------------------------------------------
   // Display read data
   // ---------------------------------------------------------------------------
   // disp_rd_d marks that vram_q carries a display pixel this cycle. A slot
   // lost to the CPU leaves it low, so the held pixel is repeated.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         disp_rd_d <= 1'b0;
         disp_hold <= '0;
      end else begin
         disp_rd_d <= disp_req && (state != ISSUE);
         if (disp_rd_d) disp_hold <= vram_q;
      end
   end

   assign disp_q = disp_rd_d ? vram_q : disp_hold;

endmodule
